background_frame_mem: RTL and testbench
=======================================

Name: background_frame_mem

Overview:
- AXI4-Lite-style memory responder that stores the background/previous-frame pixels for the motion detector.
- Sits on the far side of the detector's memory master port and implements the same reduced channel set: AW, W, AR, R, with no B channel and no response codes.
- Word-addressed single-port-write / single-port-read RAM with write-pairing buffers and a primed read-data register, so rvalid is already high before the first read request.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr.
- DATA_WIDTH, 32, pixel word width; must equal the detector stream width.
- DEPTH_BITS, 21, log2 of the word count (2^21 covers 2048x1024 frames); benches use 4.
- ADDR_LSB, 0, low address bits dropped before indexing; 0 means word addressing.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address accepted.
- s_axi_awaddr  in  ADDR_WIDTH  write word address.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data accepted.
- s_axi_wdata  in  DATA_WIDTH  write pixel.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address accepted.
- s_axi_araddr  in  ADDR_WIDTH  read word address.
- s_axi_rvalid  out  1  rdata valid.
- s_axi_rready  in  1  master consumes rdata.
- s_axi_rdata  out  DATA_WIDTH  read pixel.
- init_done  out  1  high once in RUN.
- addr_err  out  1  sticky; out-of-range access seen.

Behaviour:
- Reset: all outputs are driven low on a clock edge with rst_n=0. rdata=0, rvalid=0, addr_err=0, init_done=0; all readies are 0. Holding registers are cleared. State goes to INIT if CLEAR_ON_INIT_EN is defined, otherwise to PRIME.
- Reset mid-operation discards any buffered half-write. RAM contents are not reset unless INIT runs.
- Index = addr >> ADDR_LSB. The address is out of range if any bit above DEPTH_BITS+ADDR_LSB-1 is set.
- State INIT (optional feature): counter walks 0..2^DEPTH_BITS-1 writing 0, one word per cycle. All readies are 0 and rvalid=0. Go to PRIME after the last word.
- State PRIME: at the next edge, rdata<=mem[0] and rvalid<=1; go to RUN. Exactly 1 cycle.
- State RUN: init_done=1.
- Write path uses a 1-deep AW holding register and a 1-deep W holding register.
  - awready = !aw_full and wready = !w_full, in RUN only.
  - Commit mem[idx]<=data at the edge where both halves are available, whether from holding registers or arriving in that cycle.
  - A same-cycle AW+W with empty holding registers commits at that edge with zero buffering.
  - A lone half is buffered; the next matching half commits it. The already-full side deasserts its ready until the commit.
- Read path:
  - arready = RUN && (!rvalid || rready).
  - On AR handshake: rdata<=mem[idx] and rvalid<=1 at the next edge, giving 1-cycle latency.
  - AR handshake together with rready: rvalid stays 1 and rdata is replaced. This gives back-to-back throughput of one read per cycle.
  - rready without an AR handshake: rvalid<=0 at the next edge.
  - rdata is held stable while rvalid && !rready.
- Read/write collision on the same index in the same edge: the read returns the old data (read-before-write).
- Out-of-range access: a write is dropped, a read returns 0, and addr_err<=1, sticky until reset. The handshake still completes normally.
- Read path and write path are independent; a write commit never stalls a read.

Optional Feature:
- CLEAR_ON_INIT_EN defined: INIT state zero-fills the RAM after every reset. init_done rises 2^DEPTH_BITS+1 cycles after reset release.
- CLEAR_ON_INIT_EN undefined: there is no INIT state. Reset goes directly to PRIME, init_done rises 1 cycle after release, and RAM contents are undefined until written. Benches must not check the first-frame read data in that case.

Decomposition:
- Package dmd_mem_pkg holds:
  - mem_state_t enum {INIT, PRIME, RUN};
  - a localparam function for the out-of-range check;
  - default width constants shared with the detector.
- One sub-module, frame_mem_ram: an inferred synchronous RAM with 1 write port and 1 registered read port, read-before-write. Parameters are DATA_WIDTH and DEPTH_BITS.

Test Plan (DEPTH_BITS=4, ADDR_LSB=0):
- Reset release with CLEAR_ON_INIT_EN defined -> readies low for 16 cycles. Then PRIME, then rvalid=1, rdata=0, init_done=1 on cycle 18.
- Same-cycle AW=3, W=32'hA5A5_0001; then AR=3 with rready -> next cycle rdata=32'hA5A5_0001 and rvalid stays 1.
- AW=5 alone, 4 idle cycles, then W=32'h0000_00FF -> awready low while buffered. Commit on the W edge; a read of 5 returns 32'h0000_00FF.
- Same edge: write index 7 = 32'h2 and read index 7, where index 7 previously held 32'h1 -> rdata=32'h1. A following read of 7 returns 32'h2.
- rvalid=1 with rready=0 and arvalid=1 for 3 cycles -> arready=0 and rdata stable. Raising rready accepts the AR and the new data appears 1 cycle later.
- Write to address 16 and read address 20 -> no RAM change, rdata=0, addr_err=1, which persists until rst_n=0.

Source files
------------

// File: rtl/background_frame_mem_pkg.sv
// Shared types and constants for the background frame memory and the detector it serves.
package dmd_mem_pkg;

  localparam int DMD_ADDR_WIDTH = 32;
  localparam int DMD_DATA_WIDTH = 32;
  localparam int DMD_DEPTH_BITS = 21;
  localparam int DMD_ADDR_LSB   = 0;

  typedef enum logic [1:0] {
    INIT,
    PRIME,
    RUN
  } mem_state_t;

  // An address is out of range when any bit at or above hi_bit is set.
  function automatic logic addr_oor(input logic [63:0] addr, input int hi_bit);
    return (hi_bit >= 64) ? 1'b0 : |(addr >> hi_bit);
  endfunction

endpackage

// File: rtl/background_frame_mem_if.sv
// Reduced AXI4-Lite-style channel set (AW, W, AR, R) between the detector and its frame memory.
interface background_frame_mem_if
  import dmd_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMD_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMD_DATA_WIDTH
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/frame_mem_ram.sv
// Inferred synchronous RAM: one write port, one registered read port, read-before-write.
module frame_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_BITS = 21
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_BITS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Both ports use non-blocking updates, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/background_frame_mem.sv
// Background/previous-frame pixel store answering the detector's AW/W/AR/R memory port.
// Build macro CLEAR_ON_INIT_EN adds an INIT state that zero-fills the RAM after every reset.
module background_frame_mem
  import dmd_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMD_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMD_DATA_WIDTH,
  parameter int DEPTH_BITS = DMD_DEPTH_BITS,
  parameter int ADDR_LSB   = DMD_ADDR_LSB
) (
  input  logic                  clk,
  input  logic                  rst_n,
  background_frame_mem_if.slave s_axi,
  output logic                  init_done,
  output logic                  addr_err
);
  localparam int HI_BIT = DEPTH_BITS + ADDR_LSB;

  mem_state_t            state_q, state_d;
  logic                  aw_full_q, aw_full_d;
  logic [DEPTH_BITS-1:0] aw_idx_q, aw_idx_d;
  logic                  aw_oor_q, aw_oor_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rzero_q, rzero_d;
  logic                  addr_err_q, addr_err_d;
`ifdef CLEAR_ON_INIT_EN
  logic [DEPTH_BITS-1:0] init_cnt_q, init_cnt_d;
`endif

  logic [ADDR_WIDTH-1:0] awaddr_w, araddr_w;
  logic [DEPTH_BITS-1:0] in_aw_idx, ar_idx;
  logic                  in_aw_oor, ar_oor, wr_oor;
  logic                  run, aw_hs, w_hs, ar_hs, commit;
  logic                  ram_we, ram_re;
  logic [DEPTH_BITS-1:0] ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  assign awaddr_w  = s_axi.awaddr;
  assign araddr_w  = s_axi.araddr;
  assign in_aw_idx = DEPTH_BITS'(awaddr_w >> ADDR_LSB);
  assign ar_idx    = DEPTH_BITS'(araddr_w >> ADDR_LSB);
  assign in_aw_oor = addr_oor(64'(awaddr_w), HI_BIT);
  assign ar_oor    = addr_oor(64'(araddr_w), HI_BIT);

  assign run            = (state_q == RUN);
  assign s_axi.awready  = run && !aw_full_q;
  assign s_axi.wready   = run && !w_full_q;
  assign s_axi.arready  = run && (!rvalid_q || s_axi.rready);
  assign s_axi.rvalid   = rvalid_q;
  // rzero_q masks the RAM output after reset and after an out-of-range read.
  assign s_axi.rdata    = rzero_q ? '0 : ram_rdata;
  assign init_done      = run;
  assign addr_err       = addr_err_q;

  assign aw_hs  = s_axi.awvalid && s_axi.awready;
  assign w_hs   = s_axi.wvalid && s_axi.wready;
  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign commit = (aw_full_q || aw_hs) && (w_full_q || w_hs);
  assign wr_oor = aw_full_q ? aw_oor_q : in_aw_oor;

  always_comb begin
    state_d    = state_q;
    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    aw_oor_d   = aw_oor_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    rvalid_d   = rvalid_q;
    rzero_d    = rzero_q;
    addr_err_d = addr_err_q;
`ifdef CLEAR_ON_INIT_EN
    init_cnt_d = init_cnt_q;
`endif
    ram_we    = 1'b0;
    ram_waddr = aw_full_q ? aw_idx_q : in_aw_idx;
    ram_wdata = w_full_q ? w_data_q : s_axi.wdata;
    ram_re    = 1'b0;
    ram_raddr = ar_idx;

    unique case (state_q)
      INIT: begin
`ifdef CLEAR_ON_INIT_EN
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdata  = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) state_d = PRIME;
`else
        state_d = PRIME;
`endif
      end
      PRIME: begin
        ram_re    = 1'b1;
        ram_raddr = '0;
        rvalid_d  = 1'b1;
        rzero_d   = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        if (ar_hs) begin
          ram_re   = 1'b1;
          rvalid_d = 1'b1;
          rzero_d  = ar_oor;
        end else if (s_axi.rready) begin
          rvalid_d = 1'b0;
        end

        if (commit) begin
          ram_we    = !wr_oor;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end else begin
          if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = in_aw_idx;
            aw_oor_d  = in_aw_oor;
          end
          if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.wdata;
          end
        end
        addr_err_d = addr_err_q | (ar_hs & ar_oor) | (commit & wr_oor);
      end
      default: state_d = PRIME;
    endcase

    // Nothing reaches the RAM on a reset edge, even if the old state was RUN.
    if (!rst_n) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef CLEAR_ON_INIT_EN
      state_q    <= INIT;
      init_cnt_q <= '0;
`else
      state_q    <= PRIME;
`endif
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      aw_oor_q   <= 1'b0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      rvalid_q   <= 1'b0;
      rzero_q    <= 1'b1;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
`ifdef CLEAR_ON_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      aw_oor_q   <= aw_oor_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      rvalid_q   <= rvalid_d;
      rzero_q    <= rzero_d;
      addr_err_q <= addr_err_d;
    end
  end

  frame_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_background_frame_mem.sv
// Bench for background_frame_mem: directed scenarios plus random traffic against a word-level model.
module tb_background_frame_mem;
  localparam int DEPTH = 16;
`ifdef CLEAR_ON_INIT_EN
  localparam int INIT_EDGES = 17;
`else
  localparam int INIT_EDGES = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done, addr_err;
  int   n_checks = 0;
  int   n_errors = 0;

  background_frame_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  background_frame_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_BITS (4),
    .ADDR_LSB   (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_axi     (bus.slave),
    .init_done (init_done),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  // Word-level model: memory image, pending write halves, read-data register.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_live = 0;
  bit          m_run = 0;
  int          m_wait = 0;
  bit          m_awb = 0;
  logic [31:0] m_awa = '0;
  bit          m_wb = 0;
  logic [31:0] m_wd = '0;
  bit          m_rvalid = 0;
  logic [31:0] m_rdata = '0;
  bit          m_rknown = 0;
  bit          m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit aw_hs, input bit w_hs, input bit ar_hs);
    if (!rst_n) begin
      m_live = 1; m_run = 0; m_wait = INIT_EDGES;
      m_awb = 0; m_wb = 0; m_rvalid = 0; m_rdata = '0; m_rknown = 1; m_err = 0;
`ifdef CLEAR_ON_INIT_EN
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1; end
`endif
      return;
    end
    if (!m_live) return;
    if (!m_run) begin
      m_wait--;
      if (m_wait == 0) begin
        m_run = 1; m_rvalid = 1; m_rdata = m_mem[0]; m_rknown = m_known[0];
      end
      return;
    end
    // Read first so a same-edge write to the same word is not visible yet.
    if (ar_hs) begin
      if (bus.araddr >= DEPTH) begin
        m_rdata = '0; m_rknown = 1; m_err = 1;
      end else begin
        m_rdata = m_mem[bus.araddr[3:0]]; m_rknown = m_known[bus.araddr[3:0]];
      end
      m_rvalid = 1;
      $display("t=%0t read  addr=%0d", $time, bus.araddr);
    end else if (bus.rready) begin
      m_rvalid = 0;
    end
    if (aw_hs) begin m_awb = 1; m_awa = bus.awaddr; end
    if (w_hs)  begin m_wb = 1;  m_wd = bus.wdata;   end
    if (m_awb && m_wb) begin
      if (m_awa < DEPTH) begin
        m_mem[m_awa[3:0]] = m_wd; m_known[m_awa[3:0]] = 1;
      end else begin
        m_err = 1;
      end
      $display("t=%0t write addr=%0d data=%h", $time, m_awa, m_wd);
      m_awb = 0; m_wb = 0;
    end
  endtask

  // One clock: readies checked mid-low-phase, registered outputs checked on the falling edge.
  task automatic cycle();
    bit exp_aw, exp_w, exp_ar, aw_hs, w_hs, ar_hs;
    #1;
    exp_aw = m_run && !m_awb;
    exp_w  = m_run && !m_wb;
    exp_ar = m_run && (!m_rvalid || bus.rready);
    if (m_live) begin
      check("awready", 32'(bus.awready), 32'(exp_aw));
      check("wready",  32'(bus.wready),  32'(exp_w));
      check("arready", 32'(bus.arready), 32'(exp_ar));
    end
    aw_hs = bus.awvalid && exp_aw;
    w_hs  = bus.wvalid && exp_w;
    ar_hs = bus.arvalid && exp_ar;
    @(posedge clk);
    model_edge(aw_hs, w_hs, ar_hs);
    @(negedge clk);
    if (m_live) begin
      check("rvalid",    32'(bus.rvalid), 32'(m_rvalid));
      check("addr_err",  32'(addr_err),   32'(m_err));
      check("init_done", 32'(init_done),  32'(m_run));
      if (m_rknown) check("rdata", bus.rdata, m_rdata);
    end
  endtask

  task automatic idle(input logic rr);
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.rready = rr;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    idle(0);
    bus.awvalid = 1; bus.awaddr = a; bus.wvalid = 1; bus.wdata = d;
    cycle();
    idle(0);
  endtask

  task automatic do_read(input logic [31:0] a);
    idle(1);
    bus.arvalid = 1; bus.araddr = a;
    cycle();
    idle(0);
  endtask

  task automatic wait_init();
    int cnt = 0;
    while (!init_done && cnt < 100) begin
      cycle();
      cnt++;
    end
    check("init_latency", 32'(cnt), 32'(INIT_EDGES));
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(0, 9) == 0) ? 32'($urandom_range(16, 40)) : 32'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    idle(0);
    bus.awaddr = '0; bus.wdata = '0; bus.araddr = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata",  bus.rdata,       32'h0);
    check("rst_awready", 32'(bus.awready), 32'h0);
    rst_n = 1;
    wait_init();
`ifdef CLEAR_ON_INIT_EN
    check("init_rdata", bus.rdata, 32'h0);
`endif

    // Same-cycle AW+W, then a read while rvalid is already high.
    do_write(32'd0, 32'h0000_1234);
    do_write(32'd3, 32'hA5A5_0001);
    do_read(32'd3);
    check("rd3_data",   bus.rdata,           32'hA5A5_0001);
    check("rd3_rvalid", 32'(bus.rvalid),     32'h1);

    // Lone AW buffered for several cycles, W arrives later.
    idle(0); bus.awvalid = 1; bus.awaddr = 32'd5;
    cycle();
    idle(0);
    for (int i = 0; i < 4; i++) begin
      #1 check("aw_hold", 32'(bus.awready), 32'h0);
      cycle();
    end
    bus.wvalid = 1; bus.wdata = 32'h0000_00FF;
    cycle();
    idle(0);
    do_read(32'd5);
    check("rd5_data", bus.rdata, 32'h0000_00FF);

    // Read-before-write collision on index 7.
    do_write(32'd7, 32'h1);
    idle(1);
    bus.awvalid = 1; bus.awaddr = 32'd7; bus.wvalid = 1; bus.wdata = 32'h2;
    bus.arvalid = 1; bus.araddr = 32'd7;
    cycle();
    idle(0);
    check("rbw_old", bus.rdata, 32'h1);
    do_read(32'd7);
    check("rbw_new", bus.rdata, 32'h2);

    // Backpressure: rvalid held, AR stalled, rdata stable.
    idle(0); bus.arvalid = 1; bus.araddr = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #1 check("ar_stall", 32'(bus.arready), 32'h0);
      cycle();
      check("rdata_stable", bus.rdata, 32'h2);
    end
    bus.rready = 1;
    cycle();
    idle(0);
    check("stall_release", bus.rdata, 32'hA5A5_0001);

    // Out-of-range write and read.
    idle(1);
    bus.awvalid = 1; bus.awaddr = 32'd16; bus.wvalid = 1; bus.wdata = 32'hDEAD_BEEF;
    bus.arvalid = 1; bus.araddr = 32'd20;
    cycle();
    idle(0);
    check("oor_err",   32'(addr_err), 32'h1);
    check("oor_rdata", bus.rdata,     32'h0);
    do_read(32'd0);
    check("oor_nochange", bus.rdata, 32'h0000_1234);
    for (int i = 0; i < 3; i++) cycle();
    check("err_sticky", 32'(addr_err), 32'h1);

    // Reset with a half-write buffered: it must be discarded.
    do_write(32'd9, 32'h0000_0099);
    idle(0); bus.awvalid = 1; bus.awaddr = 32'd9;
    cycle();
    idle(0);
    rst_n = 0;
    cycle(); cycle();
    check("rst_err_clr", 32'(addr_err), 32'h0);
    rst_n = 1;
    wait_init();
    idle(0); bus.wvalid = 1; bus.wdata = 32'h0000_0055;
    cycle();
    idle(0); bus.awvalid = 1; bus.awaddr = 32'd10;
    cycle();
    idle(0);
    do_read(32'd10);
    check("post_rst_wr", bus.rdata, 32'h0000_0055);
    do_read(32'd9);
`ifdef CLEAR_ON_INIT_EN
    check("post_rst_keep", bus.rdata, 32'h0);
`else
    check("post_rst_keep", bus.rdata, 32'h0000_0099);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      bus.awvalid = ($urandom_range(0, 2) == 0);
      bus.awaddr  = rand_addr();
      bus.wvalid  = ($urandom_range(0, 2) == 0);
      bus.wdata   = $urandom();
      bus.arvalid = ($urandom_range(0, 1) == 1);
      bus.araddr  = rand_addr();
      bus.rready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle(0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
